glb_core_proc_router_pipe: RTL and testbench

Next-generation processor-packet router for one GLB tile. It moves write and read-request packets east and west along the tile chain through a parametrised pipeline, and forwards them to the local core switch. Unlike the single-stage router, it never overwrites a passing read response with a local one. Local responses that collide with chain traffic go into a small order-preserving response FIFO and are inserted into the next empty chain slot.

---
 rtl/glb_core_proc_router_pipe_pkg.sv | 36 +++
 rtl/glb_core_proc_router_pipe_rdrs_fifo.sv | 70 +++++++
 rtl/glb_core_proc_router_pipe.sv | 132 +++++++++++++
 tb/tb_glb_core_proc_router_pipe.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/glb_core_proc_router_pipe_pkg.sv
// Shared types and defaults for the pipelined GLB processor-packet router.
package glb_core_proc_router_pipe_pkg;

    localparam int TILE_SEL_ADDR_WIDTH = 5;
    localparam int BANK_DATA_WIDTH     = 64;
    localparam int BANK_STRB_WIDTH     = 8;
    localparam int GLB_ADDR_WIDTH      = 19;

    // Top-level defaults for the router pipeline and local response queue.
    localparam int GLB_PROC_ROUTER_PIPE_DEPTH = 1;
    localparam int GLB_RDRS_FIFO_DEPTH        = 4;

    typedef struct packed {
        logic                       wr_en;
        logic [BANK_STRB_WIDTH-1:0] wr_strb;
        logic [GLB_ADDR_WIDTH-1:0]  wr_addr;
        logic [BANK_DATA_WIDTH-1:0] wr_data;
    } wr_packet_t;

    typedef struct packed {
        logic                      rd_en;
        logic [GLB_ADDR_WIDTH-1:0] rd_addr;
    } rdrq_packet_t;

    typedef struct packed {
        logic [BANK_DATA_WIDTH-1:0] rd_data;
        logic                       rd_data_valid;
    } rdrs_packet_t;

    typedef struct packed {
        wr_packet_t   wr;
        rdrq_packet_t rdrq;
        rdrs_packet_t rdrs;
    } packet_t;

endpackage

// File: rtl/glb_core_proc_router_pipe_rdrs_fifo.sv
// glb_rdrs_fifo: order-preserving queue for local read responses that lost
// the chain slot. Simultaneous push and pop are accepted at any occupancy,
// including full; a push into a full queue without a pop is dropped and
// reported on drop_o.
module glb_rdrs_fifo
    import glb_core_proc_router_pipe_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  rdrs_packet_t                 din_i,
    output rdrs_packet_t                 head_o,
    output logic                         empty_o,
    output logic                         full_o,
    output logic [$clog2(DEPTH):0]       count_o,
    output logic                         drop_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    rdrs_packet_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && (!full_q || do_pop);
    assign drop_o  = push_i && full_q && !do_pop;

    // Occupancy after this cycle's accepted push/pop.
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers, count and registered full flag; pointers wrap on power-of-2 depth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
        end
    end

    // Storage; contents are only observed while the queue is non-empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = full_q;
    assign count_o = count_q;

endmodule

// File: rtl/glb_core_proc_router_pipe.sv
// glb_core_proc_router_pipe: pipelined processor-packet router for one GLB
// tile. Chain traffic moves through PIPE_DEPTH stages per direction; local
// read responses never overwrite a passing chain response and are queued
// until an empty merge-direction slot appears.
// Optional macro GLB_PROC_ROUTER_OVERFLOW_FLAG_EN enables the sticky
// rdrs_overflow flag (and a simulation warning on each dropped response).
module glb_core_proc_router_pipe
    import glb_core_proc_router_pipe_pkg::*;
#(
    parameter int PIPE_DEPTH      = GLB_PROC_ROUTER_PIPE_DEPTH,
    parameter int RDRS_FIFO_DEPTH = GLB_RDRS_FIFO_DEPTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [TILE_SEL_ADDR_WIDTH-1:0] glb_tile_id,
    input  packet_t                        packet_w2e_wsti,
    output packet_t                        packet_e2w_wsto,
    input  packet_t                        packet_e2w_esti,
    output packet_t                        packet_w2e_esto,
    output wr_packet_t                     wr_packet_pr2sw,
    output rdrq_packet_t                   rdrq_packet_pr2sw,
    input  rdrs_packet_t                   rdrs_packet_sw2pr,
    output logic                           rdrs_fifo_full,
    output logic                           rdrs_overflow,
    input  logic                           rdrs_overflow_clr
);

    localparam int LAST = PIPE_DEPTH - 1;

    packet_t      w2e_q [PIPE_DEPTH];
    packet_t      e2w_q [PIPE_DEPTH];
    rdrs_packet_t loc_q;

    logic         is_even;
    packet_t      merge_last;
    rdrs_packet_t merge_rdrs;
    rdrs_packet_t fifo_head;
    logic         fifo_push, fifo_pop, fifo_empty, fifo_drop;
    logic [$clog2(RDRS_FIFO_DEPTH):0] fifo_count_unused;
    logic         unused_tile_bits;

    assign is_even          = ~glb_tile_id[0];
    assign unused_tile_bits = ^glb_tile_id[TILE_SEL_ADDR_WIDTH-1:1];

    // Chain shift registers (both directions) and the one-cycle local response register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                w2e_q[i] <= '0;
                e2w_q[i] <= '0;
            end
            loc_q <= '0;
        end else begin
            w2e_q[0] <= packet_w2e_wsti;
            e2w_q[0] <= packet_e2w_esti;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                w2e_q[i] <= w2e_q[i-1];
                e2w_q[i] <= e2w_q[i-1];
            end
            loc_q <= rdrs_packet_sw2pr;
        end
    end

    assign merge_last = is_even ? w2e_q[LAST] : e2w_q[LAST];

    // Merge-slot arbitration: chain first, then queued local, then bypass.
    always_comb begin
        merge_rdrs = merge_last.rdrs;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        if (merge_last.rdrs.rd_data_valid) begin
            fifo_push = loc_q.rd_data_valid;
        end else if (!fifo_empty) begin
            merge_rdrs = fifo_head;
            fifo_pop   = 1'b1;
            fifo_push  = loc_q.rd_data_valid;
        end else if (loc_q.rd_data_valid) begin
            merge_rdrs = loc_q;
        end
    end

    glb_rdrs_fifo #(
        .DEPTH (RDRS_FIFO_DEPTH)
    ) u_rdrs_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   (loc_q),
        .head_o  (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (rdrs_fifo_full),
        .count_o (fifo_count_unused),
        .drop_o  (fifo_drop)
    );

    // Chain outputs: pass direction untouched, merge direction carries the arbitrated response.
    always_comb begin
        packet_w2e_esto = w2e_q[LAST];
        packet_e2w_wsto = e2w_q[LAST];
        if (is_even) packet_w2e_esto.rdrs = merge_rdrs;
        else         packet_e2w_wsto.rdrs = merge_rdrs;
    end

    assign wr_packet_pr2sw   = merge_last.wr;
    assign rdrq_packet_pr2sw = merge_last.rdrq;

`ifdef GLB_PROC_ROUTER_OVERFLOW_FLAG_EN
    logic overflow_q;

    // Sticky drop flag; a new drop wins over a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  overflow_q <= 1'b0;
        else if (fifo_drop)         overflow_q <= 1'b1;
        else if (rdrs_overflow_clr) overflow_q <= 1'b0;
    end

    assign rdrs_overflow = overflow_q;

`ifndef SYNTHESIS
    // Flag every local response lost to a full queue.
    always @(posedge clk) begin
        if (!reset) assert (!fifo_drop) else $warning("local read response dropped, queue full");
    end
`endif
`else
    logic unused_ovf_inputs;
    assign unused_ovf_inputs = rdrs_overflow_clr ^ fifo_drop;
    assign rdrs_overflow     = 1'b0;
`endif

endmodule

// File: tb/tb_glb_core_proc_router_pipe.sv
// Directed bench for glb_core_proc_router_pipe (PIPE_DEPTH=3, queue depth 4).
module tb_glb_core_proc_router_pipe;
    import glb_core_proc_router_pipe_pkg::*;

    localparam int PD = 3;
    localparam int FD = 4;
`ifdef GLB_PROC_ROUTER_OVERFLOW_FLAG_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic                           clk = 1'b0;
    logic                           reset;
    logic [TILE_SEL_ADDR_WIDTH-1:0] tile_id;
    packet_t                        w2e_in, e2w_in, esto, wsto;
    wr_packet_t                     wr_sw;
    rdrq_packet_t                   rdrq_sw;
    rdrs_packet_t                   loc_in;
    logic                           fifo_full, ovf, ovf_clr;

    int total = 0;
    int bad   = 0;

    logic [63:0] e_in  [32];
    logic [63:0] w_in  [32];
    logic [63:0] l_in  [32];
    logic [63:0] exp_e [32];
    logic [63:0] exp_w [32];
    int          exp_full [32];

    glb_core_proc_router_pipe #(
        .PIPE_DEPTH      (PD),
        .RDRS_FIFO_DEPTH (FD)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .glb_tile_id       (tile_id),
        .packet_w2e_wsti   (w2e_in),
        .packet_e2w_wsto   (wsto),
        .packet_e2w_esti   (e2w_in),
        .packet_w2e_esto   (esto),
        .wr_packet_pr2sw   (wr_sw),
        .rdrq_packet_pr2sw (rdrq_sw),
        .rdrs_packet_sw2pr (loc_in),
        .rdrs_fifo_full    (fifo_full),
        .rdrs_overflow     (ovf),
        .rdrs_overflow_clr (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_vec();
        for (int i = 0; i < 32; i++) begin
            e_in[i] = '0; w_in[i] = '0; l_in[i] = '0;
            exp_e[i] = '0; exp_w[i] = '0; exp_full[i] = -1;
        end
    endtask

    // Drive row k of the vectors, advance one cycle, check output row k.
    task automatic run_seq(input string name, input int n);
        for (int k = 0; k < n; k++) begin
            w2e_in = '0;
            e2w_in = '0;
            loc_in = '0;
            w2e_in.rdrs.rd_data       = e_in[k];
            w2e_in.rdrs.rd_data_valid = (e_in[k] != '0);
            e2w_in.rdrs.rd_data       = w_in[k];
            e2w_in.rdrs.rd_data_valid = (w_in[k] != '0);
            loc_in.rd_data            = l_in[k];
            loc_in.rd_data_valid      = (l_in[k] != '0);
            tick();
            check_eq($sformatf("%s_esto_rdrs_%0d", name, k),
                     256'({esto.rdrs.rd_data_valid, esto.rdrs.rd_data}),
                     256'({exp_e[k] != '0, exp_e[k]}));
            check_eq($sformatf("%s_wsto_rdrs_%0d", name, k),
                     256'({wsto.rdrs.rd_data_valid, wsto.rdrs.rd_data}),
                     256'({exp_w[k] != '0, exp_w[k]}));
            if (exp_full[k] >= 0)
                check_eq($sformatf("%s_full_%0d", name, k), 256'(fifo_full), 256'(exp_full[k]));
        end
        w2e_in = '0;
        e2w_in = '0;
        loc_in = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        wr_packet_t   exp_wr_e, exp_wr_w;
        rdrq_packet_t exp_rq_e;

        reset   = 1'b1;
        tile_id = '0;
        w2e_in  = '0;
        e2w_in  = '0;
        loc_in  = '0;
        ovf_clr = 1'b0;
        clear_vec();
        tick();
        tick();
        check_eq("reset_esto", 256'(esto), 256'(0));
        check_eq("reset_wsto", 256'(wsto), 256'(0));
        check_eq("reset_full", 256'(fifo_full), 256'(0));
        check_eq("reset_ovf",  256'(ovf), 256'(0));
        reset = 1'b0;
        tick();

        // Test 1: write/read-request latency on an even tile.
        exp_wr_e = '{wr_en: 1'b1, wr_strb: 8'hFF, wr_addr: 19'h100, wr_data: 64'hDEAD};
        exp_wr_w = '{wr_en: 1'b1, wr_strb: 8'h0F, wr_addr: 19'h200, wr_data: 64'hBEEF};
        exp_rq_e = '{rd_en: 1'b1, rd_addr: 19'h150};
        w2e_in.wr   = exp_wr_e;
        w2e_in.rdrq = exp_rq_e;
        e2w_in.wr   = exp_wr_w;
        tick();
        w2e_in = '0;
        e2w_in = '0;
        check_eq("t1_early1_esto_wr", 256'(esto.wr.wr_en), 256'(0));
        tick();
        check_eq("t1_early2_esto_wr", 256'(esto.wr.wr_en), 256'(0));
        check_eq("t1_early2_wsto_wr", 256'(wsto.wr.wr_en), 256'(0));
        tick();
        check_eq("t1_esto_wr",  256'(esto.wr), 256'(exp_wr_e));
        check_eq("t1_esto_rq",  256'(esto.rdrq), 256'(exp_rq_e));
        check_eq("t1_core_wr",  256'(wr_sw), 256'(exp_wr_e));
        check_eq("t1_core_rq",  256'(rdrq_sw), 256'(exp_rq_e));
        check_eq("t1_wsto_wr",  256'(wsto.wr), 256'(exp_wr_w));
        tick();
        check_eq("t1_after_esto_wr", 256'(esto.wr.wr_en), 256'(0));
        check_eq("t1_after_core_wr", 256'(wr_sw.wr_en), 256'(0));

        // Test 2: idle chain, local response bypasses with latency 1.
        clear_vec();
        l_in[0] = 64'hAAAA;
        exp_e[0] = 64'hAAAA;
        exp_full[0] = 0;
        exp_full[1] = 0;
        run_seq("t2", 3);

        // Test 3: chain responses keep priority; queued local ones follow with no gap.
        clear_vec();
        e_in[0] = 64'h1; e_in[1] = 64'h2; e_in[2] = 64'h3;
        l_in[2] = 64'hA; l_in[3] = 64'hB;
        w_in[0] = 64'h99;
        exp_e[2] = 64'h1; exp_e[3] = 64'h2; exp_e[4] = 64'h3;
        exp_e[5] = 64'hA; exp_e[6] = 64'hB;
        exp_w[2] = 64'h99;
        run_seq("t3", 9);

        // Test 4: chain busy 10 cycles, 6 local responses, queue of 4.
        clear_vec();
        for (int i = 0; i < 10; i++) begin
            e_in[i]    = 64'h11 + 64'(i);
            exp_e[i+2] = 64'h11 + 64'(i);
        end
        for (int i = 0; i < 6; i++) l_in[i+2] = 64'hA1 + 64'(i);
        for (int i = 0; i < 4; i++) exp_e[12+i] = 64'hA1 + 64'(i);
        exp_full[5] = 0; exp_full[6] = 1; exp_full[12] = 1; exp_full[13] = 0;
        run_seq("t4", 17);
        check_eq("t4_ovf_sticky", 256'(ovf), 256'(OVF_ON));
        tick();
        check_eq("t4_ovf_still", 256'(ovf), 256'(OVF_ON));
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check_eq("t4_ovf_cleared", 256'(ovf), 256'(0));

        // Test 5: odd tile merges westbound; eastbound responses pass untouched.
        tile_id = 5'd1;
        clear_vec();
        l_in[0] = 64'h55;
        e_in[0] = 64'h77;
        w_in[1] = 64'h66;
        exp_w[0] = 64'h55;
        exp_e[2] = 64'h77;
        exp_w[3] = 64'h66;
        run_seq("t5", 6);
        e2w_in.wr = '{wr_en: 1'b1, wr_strb: 8'h01, wr_addr: 19'h300, wr_data: 64'h5};
        tick();
        e2w_in = '0;
        tick();
        tick();
        check_eq("t5_core_wr_addr", 256'({wr_sw.wr_en, wr_sw.wr_addr}), 256'({1'b1, 19'h300}));

        // Test 6: asynchronous reset with a partly filled queue and a full pipeline.
        tile_id = 5'd0;
        clear_vec();
        for (int i = 0; i < 6; i++) e_in[i] = 64'h21 + 64'(i);
        for (int i = 0; i < 4; i++) exp_e[i+2] = 64'h21 + 64'(i);
        l_in[2] = 64'hB1; l_in[3] = 64'hB2; l_in[4] = 64'hB3;
        run_seq("t6_fill", 6);
        #1 reset = 1'b1;
        #1;
        check_eq("t6_rst_esto", 256'(esto), 256'(0));
        check_eq("t6_rst_wsto", 256'(wsto), 256'(0));
        check_eq("t6_rst_core_wr", 256'(wr_sw), 256'(0));
        check_eq("t6_rst_core_rq", 256'(rdrq_sw), 256'(0));
        check_eq("t6_rst_full", 256'(fifo_full), 256'(0));
        #1 reset = 1'b0;
        clear_vec();
        run_seq("t6_after", 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
